// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the data word type used by the FIFO, its interface and the bench.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  typedef logic [FIFO_WIDTH-1:0] data_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, synchronous registered read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = FIFO_WIDTH,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value unless a read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/async_fifo.sv
// Single-clock FIFO with full/empty flags and one-cycle overflow/underflow pulses.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = FIFO_WIDTH,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic             wr_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come straight from the registered pointers; MSB is the wrap bit.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  assign wr_acc = wr_en && !full && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wptr <= '0;
    end else if (wr_acc) begin
      wptr <= wptr + PTR_W'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      rptr <= '0;
    end else if (rd_acc) begin
      rptr <= rptr + PTR_W'(1);
    end
  end

  // Error pulses repeat every cycle a request is rejected.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (wr_clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus predicts read data into a queue, a monitor checks it.
module tb_async_fifo;
  import fifo_pkg::*;

  localparam int unsigned DEPTH = FIFO_DEPTH;

  logic  wr_clk = 1'b0;
  logic  rst = 1'b0;
  logic  wr_en = 1'b0;
  data_t wdata = '0;
  logic  rd_en = 1'b0;
  data_t rdata;
  logic  full, empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  data_t model_q[$];
  data_t exp_q[$];
  data_t last_exp = '0;

  always #5 wr_clk = ~wr_clk;

  async_fifo dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, check flags and pulses after the edge.
  task automatic cycle(input logic we, input data_t wd, input logic re);
    bit acc_w, acc_r;
    acc_w = we && (model_q.size() < DEPTH);
    acc_r = re && (model_q.size() > 0);
    wr_en = we;
    wdata = wd;
    rd_en = re;
    if (acc_r) begin
      last_exp = model_q.pop_front();
      exp_q.push_back(last_exp);
    end
    if (acc_w) model_q.push_back(wd);
    @(posedge wr_clk);
    #1;
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(we && !acc_w));
    chk("underflow", 32'(underflow), 32'(re && !acc_r));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < n; i++) @(posedge wr_clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    last_exp = '0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
  endtask

  // Monitor: when the DUT accepts a read, the next negedge must show the predicted word.
  initial begin
    bit acc;
    data_t e;
    forever begin
      @(posedge wr_clk);
      acc = rd_en && !empty && !rst;
      @(negedge wr_clk);
      if (acc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdata_unexpected: got 0x%0h expected no read at %0t", rdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 32'(rdata), 32'(e));
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset(2);

    // Fill with 0x01..0x10, then drain in order
    for (int i = 1; i <= 16; i++) cycle(1'b1, data_t'(i), 1'b0);
    chk("full_after_16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    chk("empty_after_drain", 32'(empty), 32'd1);

    // Overflow: full plus 0xAA, pulse lasts exactly one cycle, 0xAA never comes out
    for (int i = 0; i < 16; i++) cycle(1'b1, data_t'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    // Simultaneous at full: read accepted, write rejected
    cycle(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);

    // Underflow: rdata holds the last word read
    cycle(1'b0, '0, 1'b1);
    chk("udf_rdata_hold", 32'(rdata), 32'(last_exp));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("udf_rdata_hold2", 32'(rdata), 32'h2F);

    // Simultaneous at empty: write accepted, read rejected
    cycle(1'b1, 8'h5A, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Wrap-around: 40 write/read pairs, then overlapped traffic with one word in flight
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, data_t'(i), 1'b0);
      cycle(1'b0, '0, 1'b1);
    end
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, data_t'(8'h81 + i), 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Mid-operation reset after 5 writes
    for (int i = 0; i < 5; i++) cycle(1'b1, data_t'(8'hC0 + i), 1'b0);
    do_reset(1);
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_rdata", 32'(rdata), 32'd0);

    @(negedge wr_clk);
    @(negedge wr_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_async_fifo
